// File: rtl/digest_tx_handler_pkg.sv
// Shared constants and FSM encoding for the digest transmit path.
package digest_tx_handler_pkg;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam int         DIGEST_BYTES_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_FIN       = 3'd5
  } tx_state_t;

endpackage

// File: rtl/digest_tx_handler_hex_nibble_enc.sv
// Combinational nibble to lowercase hex ASCII encoder.
module digest_tx_handler_hex_nibble_enc (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0-9 map onto '0'..'9', 10-15 map onto 'a'..'f' ('a' - 10 = 8'h57)
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h57 + {4'h0, nibble};
  end

endmodule

// File: rtl/digest_tx_handler.sv
// Serializes a finished digest into the UART transmitter, one char per
// uart frame, as raw bytes or lowercase hex with an optional CR LF tail.
module digest_tx_handler
  import digest_tx_handler_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEF,
  parameter bit HEX_ASCII    = 1'b1,
  parameter bit APPEND_EOL   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DIGEST_BYTES-1:0] digest_i,
  input  logic                    digest_valid,
  output logic                    ready,
  output logic                    transmit,
  output logic [7:0]              tx_byte,
  input  logic                    is_transmitting,
  output logic                    done
);

  localparam int DIG_W        = 8 * DIGEST_BYTES;
  localparam int DIGEST_CHARS = DIGEST_BYTES * (HEX_ASCII ? 2 : 1);
  localparam int TOTAL        = DIGEST_CHARS + (APPEND_EOL ? 2 : 0);
  localparam int CNT_W        = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_DIGEST_END = CNT_W'(DIGEST_CHARS);

  tx_state_t        state, state_nxt;
  logic [DIG_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       top_byte;
  logic [3:0]       nibble;
  logic [7:0]       nib_char;
  logic [7:0]       next_char;
  logic             in_digest;
  logic             shift_now;

  assign top_byte  = shreg[DIG_W-1 -: 8];
  assign in_digest = (cnt < CNT_DIGEST_END);
  // Even counter values carry the high nibble, odd values the low nibble
  assign nibble    = (HEX_ASCII && cnt[0]) ? top_byte[3:0] : top_byte[7:4];
  // Hex mode consumes a byte after its second char; raw mode after every char
  assign shift_now = in_digest && (HEX_ASCII ? cnt[0] : 1'b1);

  digest_tx_handler_hex_nibble_enc u_enc (
    .nibble (nibble),
    .ascii  (nib_char)
  );

  // Pick the character for the current counter position
  always_comb begin
    next_char = top_byte;
    if (!in_digest)     next_char = (cnt == CNT_DIGEST_END) ? ASCII_CR : ASCII_LF;
    else if (HEX_ASCII) next_char = nib_char;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (digest_valid) state_nxt = ST_LOAD;
      ST_LOAD:      state_nxt = ST_SEND;
      ST_SEND:      state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (is_transmitting) state_nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (!is_transmitting) state_nxt = (cnt == CNT_LAST) ? ST_FIN : ST_LOAD;
      ST_FIN:       state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready    = 1'b0;
    transmit = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: ready    = 1'b1;
      ST_SEND: transmit = 1'b1;
      ST_FIN:  done     = 1'b1;
      default: ;
    endcase
  end

  // Shift register, char counter and held output byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      cnt     <= '0;
      tx_byte <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (digest_valid) begin
            shreg <= digest_i;
            cnt   <= '0;
          end
        end
        ST_LOAD: tx_byte <= next_char;
        ST_WAIT_IDLE: begin
          if (!is_transmitting) begin
            cnt <= cnt + CNT_W'(1);
            if (shift_now) shreg <= shreg << 8;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
